// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: SPI burst sequencer with slave-select timing and TX/RX byte FIFOs
// feeding and draining an external SPI byte engine.

module spi_xfer_seq_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          wr, rd;

    assign wr    = push & ~full;
    assign rd    = pop & ~empty;
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    assign dout  = mem_q[rp_q];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) wp_q <= wp_q + 1'b1;
            if (rd) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= din;
    end
endmodule

module spi_xfer_seq #(
    parameter int DEPTH  = 4,
    parameter int SS_DLY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tx_wr,
    input  logic [7:0]               tx_data,
    output logic                     tx_full,
    output logic [$clog2(DEPTH):0]   tx_count,
    input  logic                     rx_rd,
    output logic [7:0]               rx_data,
    output logic                     rx_empty,
    output logic [$clog2(DEPTH):0]   rx_count,
    input  logic                     go,
    input  logic [7:0]               cmd_len,
    output logic                     busy,
    output logic                     done_tick,
    output logic                     ss_n,
    output logic                     spi_start,
    output logic [7:0]               spi_din,
    input  logic                     spi_ready,
    input  logic                     spi_done_tick,
    input  logic [7:0]               spi_dout
);
    typedef enum logic [2:0] {IDLE, SS_SETUP, ISSUE, WAIT_DONE, SS_HOLD} state_t;

    state_t     state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] dly_q, dly_d;
    logic       ss_n_q;
    logic       tx_empty, rx_full, rx_push, dly_last;

    spi_xfer_seq_fifo #(.DEPTH(DEPTH)) u_tx (
        .clk   (clk),
        .reset (reset),
        .push  (tx_wr),
        .pop   (spi_start),
        .din   (tx_data),
        .dout  (spi_din),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    spi_xfer_seq_fifo #(.DEPTH(DEPTH)) u_rx (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_rd),
        .din   (spi_dout),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign dly_last = dly_q == 8'(SS_DLY - 1);
    assign busy     = state_q != IDLE;
    assign ss_n     = ss_n_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        dly_d     = dly_q;
        spi_start = 1'b0;
        done_tick = 1'b0;
        rx_push   = 1'b0;
        case (state_q)
            IDLE: if (go && cmd_len != 8'd0) begin
                rem_d   = cmd_len;
                dly_d   = 8'd0;
                state_d = SS_SETUP;
            end
            SS_SETUP: begin
                dly_d   = dly_last ? 8'd0 : dly_q + 8'd1;
                state_d = dly_last ? ISSUE : SS_SETUP;
            end
            // Only issue when the reply is guaranteed a slot in the RX FIFO.
            ISSUE: if (spi_ready && !tx_empty && !rx_full) begin
                spi_start = 1'b1;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: if (spi_done_tick) begin
                rx_push = 1'b1;
                rem_d   = rem_q - 8'd1;
                state_d = (rem_q == 8'd1) ? SS_HOLD : ISSUE;
            end
            SS_HOLD: begin
                done_tick = dly_last;
                dly_d     = dly_last ? 8'd0 : dly_q + 8'd1;
                state_d   = dly_last ? IDLE : SS_HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dly_q   <= '0;
            ss_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dly_q   <= dly_d;
            ss_n_q  <= state_d == IDLE;
        end
    end
endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: directed self-checking bench for spi_xfer_seq with a simple
// SPI byte engine model that returns ~din 16 clocks after each start.

module tb_spi_xfer_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_wr = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_full;
    logic [2:0] tx_count;
    logic       rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic [2:0] rx_count;
    logic       go = 1'b0;
    logic [7:0] cmd_len = '0;
    logic       busy, done_tick, ss_n, spi_start;
    logic [7:0] spi_din;
    logic       spi_ready = 1'b1;
    logic       spi_done_tick = 1'b0;
    logic [7:0] spi_dout = '0;

    int tests = 0;
    int fails = 0;

    int         ncyc = 0, fall_cyc = 0, first_start_cyc = 0;
    int         n_start = 0, n_done = 0;
    bit         seen_start = 0;
    logic       ss_prev = 1'b1;
    logic [7:0] din_q[$];
    int         eng_cnt = 0;
    logic [7:0] eng_b;
    logic [7:0] d;

    spi_xfer_seq #(.DEPTH(4), .SS_DLY(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_wr         (tx_wr),
        .tx_data       (tx_data),
        .tx_full       (tx_full),
        .tx_count      (tx_count),
        .rx_rd         (rx_rd),
        .rx_data       (rx_data),
        .rx_empty      (rx_empty),
        .rx_count      (rx_count),
        .go            (go),
        .cmd_len       (cmd_len),
        .busy          (busy),
        .done_tick     (done_tick),
        .ss_n          (ss_n),
        .spi_start     (spi_start),
        .spi_din       (spi_din),
        .spi_ready     (spi_ready),
        .spi_done_tick (spi_done_tick),
        .spi_dout      (spi_dout)
    );

    always #5 clk = ~clk;

    // Engine model: everything changes on the falling edge, away from DUT sampling.
    always @(negedge clk) begin
        spi_done_tick = 1'b0;
        if (eng_cnt > 0) begin
            spi_ready = 1'b0;
            eng_cnt--;
            if (eng_cnt == 0) begin
                spi_dout      = eng_b;
                spi_done_tick = 1'b1;
                spi_ready     = 1'b1;
            end
        end else if (spi_start) begin
            eng_b   = ~spi_din;
            eng_cnt = 16;
        end
    end

    always @(negedge clk) begin
        ncyc++;
        if (!ss_n && ss_prev) fall_cyc = ncyc;
        if (spi_start) begin
            if (!seen_start) first_start_cyc = ncyc;
            seen_start = 1;
            din_q.push_back(spi_din);
            n_start++;
        end
        if (done_tick) n_done++;
        ss_prev = ss_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_start = 0;
        n_done = 0;
        seen_start = 0;
        din_q.delete();
    endtask

    task automatic wr(input logic [7:0] b);
        tx_wr = 1'b1;
        tx_data = b;
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic pop(output logic [7:0] b);
        b = rx_data;
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic start(input logic [7:0] len);
        go = 1'b1;
        cmd_len = len;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        check(tag, busy, 0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_ss_n", ss_n, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_full", tx_full, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_counts", {tx_count, rx_count}, 0);
        check("rst_start_done", {spi_start, done_tick}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic two-byte burst, with a stray go while busy
        wr(8'hA5);
        wr(8'h3C);
        check("a_tx_count", tx_count, 2);
        clear_mon();
        start(8'd2);
        check("a_ss_low", ss_n, 0);
        check("a_busy", busy, 1);
        repeat (5) @(negedge clk);
        start(8'd5);
        wait_idle("a_idle", 200);
        check("a_setup_cycles", first_start_cyc - fall_cyc, 2);
        check("a_n_start", n_start, 2);
        check("a_din0", din_q[0], 8'hA5);
        check("a_din1", din_q[1], 8'h3C);
        check("a_n_done", n_done, 1);
        check("a_ss_high", ss_n, 1);
        check("a_rx_count", rx_count, 2);
        pop(d);
        check("a_rx0", d, 8'h5A);
        pop(d);
        check("a_rx1", d, 8'hC3);
        check("a_rx_empty", rx_empty, 1);

        // Stall in ISSUE on empty TX, resumed by later writes
        wr(8'h11);
        clear_mon();
        start(8'd3);
        repeat (40) @(negedge clk);
        check("b_stall_starts", n_start, 1);
        check("b_stall_busy", busy, 1);
        check("b_stall_rx", rx_count, 1);
        wr(8'h7E);
        wr(8'h81);
        wait_idle("b_idle", 200);
        check("b_n_start", n_start, 3);
        check("b_din2", din_q[2], 8'h81);
        check("b_n_done", n_done, 1);
        check("b_rx_count", rx_count, 3);
        pop(d);
        check("b_rx0", d, 8'hEE);
        pop(d);
        check("b_rx1", d, 8'h81);
        pop(d);
        check("b_rx2", d, 8'h7E);

        // RX full blocks issue until the host reads
        wr(8'h01);
        wr(8'h02);
        wr(8'h04);
        wr(8'h08);
        start(8'd4);
        wait_idle("c_fill_idle", 400);
        check("c_rx_full_count", rx_count, 4);
        wr(8'h55);
        clear_mon();
        start(8'd1);
        repeat (30) @(negedge clk);
        check("c_blocked_starts", n_start, 0);
        check("c_blocked_busy", busy, 1);
        pop(d);
        check("c_rx0", d, 8'hFE);
        wait_idle("c_idle", 200);
        check("c_n_start", n_start, 1);
        check("c_din", din_q[0], 8'h55);
        check("c_n_done", n_done, 1);
        check("c_rx_count", rx_count, 4);
        pop(d);
        check("c_rx1", d, 8'hFD);
        pop(d);
        check("c_rx2", d, 8'hFB);
        pop(d);
        check("c_rx3", d, 8'hF7);
        pop(d);
        check("c_rx4", d, 8'hAA);

        // TX overflow drop and zero-length go
        for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
        check("d_tx_count", tx_count, 4);
        check("d_tx_full", tx_full, 1);
        start(8'd0);
        check("d_len0_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("d_len0_busy_later", busy, 0);

        // Reset in WAIT_DONE aborts; the engine's late reply must not land in RX
        clear_mon();
        start(8'd1);
        for (int i = 0; i < 20 && n_start == 0; i++) @(negedge clk);
        check("e_started", n_start, 1);
        check("e_din", din_q[0], 8'h10);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("e_rst_ss_n", ss_n, 1);
        check("e_rst_busy", busy, 0);
        check("e_rst_counts", {tx_count, rx_count}, 0);
        check("e_rst_empty", rx_empty, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 30 && eng_cnt != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("e_engine_quiet", eng_cnt, 0);
        check("e_stray_rx", rx_count, 0);
        check("e_stray_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
